// File: rtl/mvm_pkg.sv
// rtl/mvm_pkg.sv - shared word/vector types and feeder state encoding for the MVM front-end
package mvm_pkg;

  localparam int MVM_NUM_BIT    = 8;
  localparam int MVM_DIM        = 4;
  localparam int MVM_NUM_VECTOR = 3;

  typedef logic [MVM_NUM_BIT-1:0]            word_t;
  typedef logic [MVM_DIM-1:0][MVM_NUM_BIT-1:0] xvec_t;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/mvm_stream_feeder_if.sv
// rtl/mvm_stream_feeder_if.sv - input word stream and output result stream of the feeder
interface mvm_stream_feeder_if
  import mvm_pkg::*;
#(
  parameter int NUM_BIT = MVM_NUM_BIT
) ();

  logic               in_valid;
  logic               in_ready;
  logic [NUM_BIT-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_BIT-1:0] out_data;
  logic               out_last;

  // master is the host side, slave is the feeder
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/mvm_result_serializer.sv
// rtl/mvm_result_serializer.sv - holds the captured result vector and streams it word by word
module mvm_result_serializer #(
  parameter int NUM_BIT = 8,
  parameter int DIM     = 4
) (
  input  logic                         i_clk_topMvm,
  input  logic                         i_rst_topMvm,
  input  logic                         capture_i,
  input  logic [DIM-1:0][NUM_BIT-1:0]  y_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [NUM_BIT-1:0]           data_o,
  output logic                         last_o,
  output logic                         done_o
);

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(DIM - 1);

  logic [DIM-1:0][NUM_BIT-1:0] buf_q;
  logic [RW-1:0]               rd_q;
  logic                        valid_q;

  always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
    if (i_rst_topMvm) begin
      buf_q   <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else if (capture_i) begin
      buf_q   <= y_i;
      rd_q    <= '0;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      if (rd_q == RD_LAST) begin
        rd_q    <= '0;
        valid_q <= 1'b0;
      end else begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Data is forced to zero when idle so the bus reads 0 outside a drain
  assign valid_o = valid_q;
  assign data_o  = valid_q ? buf_q[rd_q] : '0;
  assign last_o  = valid_q && (rd_q == RD_LAST);
  assign done_o  = valid_q && ready_i && (rd_q == RD_LAST);

endmodule

// File: rtl/mvm_stream_feeder.sv
// rtl/mvm_stream_feeder.sv - frame loader, TOP_MVM start/capture handshake and result streamer
// Build option: define MVM_TIMEOUT_EN to add the WAIT watchdog and the o_error port.
module mvm_stream_feeder
  import mvm_pkg::*;
#(
  parameter int NUM_BIT    = MVM_NUM_BIT,
  parameter int DIM        = MVM_DIM,
  parameter int NUM_VECTOR = MVM_NUM_VECTOR
`ifdef MVM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                                        i_clk_topMvm,
  input  logic                                        i_rst_topMvm,
  mvm_stream_feeder_if.slave                          strm,
  output logic [NUM_VECTOR-1:0][DIM-1:0][NUM_BIT-1:0] o_x_vectors,
  output logic [NUM_VECTOR-1:0][NUM_BIT-1:0]          o_wts,
  output logic                                        o_start_topMvm,
  input  logic [DIM-1:0][NUM_BIT-1:0]                 i_y_vector,
  input  logic                                        i_isAcc
`ifdef MVM_TIMEOUT_EN
  ,
  output logic                                        o_error
`endif
);

  localparam int PW  = $clog2(DIM + 1);
  localparam int VW  = $clog2(NUM_VECTOR + 1);
  localparam int XW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int VIW = (NUM_VECTOR > 1) ? $clog2(NUM_VECTOR) : 1;
  localparam logic [PW-1:0] WR_LAST  = PW'(DIM);
  localparam logic [VW-1:0] VEC_LAST = VW'(NUM_VECTOR - 1);

  feeder_state_e                              state_q;
  logic [PW-1:0]                              wr_ptr_q;
  logic [VW-1:0]                              vec_ptr_q;
  logic [NUM_VECTOR-1:0][DIM-1:0][NUM_BIT-1:0] x_q;
  logic [NUM_VECTOR-1:0][NUM_BIT-1:0]         w_q;
  logic                                       in_ready_q;
  logic                                       start_q;
  logic                                       capture;
  logic                                       drain_done;

`ifdef MVM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wd_q;
  logic          err_q;
  assign o_error = err_q;
`endif

  // Sampled every WAIT edge, so a single-cycle isAcc low is never lost
  assign capture = (state_q == WAIT) && !i_isAcc;

  always_ff @(posedge i_clk_topMvm or posedge i_rst_topMvm) begin
    if (i_rst_topMvm) begin
      state_q    <= LOAD;
      wr_ptr_q   <= '0;
      vec_ptr_q  <= '0;
      x_q        <= '0;
      w_q        <= '0;
      in_ready_q <= 1'b1;
      start_q    <= 1'b0;
`ifdef MVM_TIMEOUT_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (strm.in_valid && in_ready_q) begin
            if (wr_ptr_q == WR_LAST) begin
              w_q[vec_ptr_q[VIW-1:0]] <= strm.in_data;
              wr_ptr_q                <= '0;
              if (vec_ptr_q == VEC_LAST) begin
                vec_ptr_q  <= '0;
                state_q    <= START;
                in_ready_q <= 1'b0;
                start_q    <= 1'b1;
              end else begin
                vec_ptr_q <= vec_ptr_q + 1'b1;
              end
            end else begin
              x_q[vec_ptr_q[VIW-1:0]][wr_ptr_q[XW-1:0]] <= strm.in_data;
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
          end
        end
        START: begin
          start_q <= 1'b0;
          state_q <= WAIT;
`ifdef MVM_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        WAIT: begin
          if (capture) begin
            state_q <= DRAIN;
          end
`ifdef MVM_TIMEOUT_EN
          else if (wd_q == TO_LAST) begin
            err_q      <= 1'b1;
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (drain_done) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= LOAD;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  mvm_result_serializer #(
    .NUM_BIT (NUM_BIT),
    .DIM     (DIM)
  ) u_serializer (
    .i_clk_topMvm (i_clk_topMvm),
    .i_rst_topMvm (i_rst_topMvm),
    .capture_i    (capture),
    .y_i          (i_y_vector),
    .ready_i      (strm.out_ready),
    .valid_o      (strm.out_valid),
    .data_o       (strm.out_data),
    .last_o       (strm.out_last),
    .done_o       (drain_done)
  );

  assign strm.in_ready  = in_ready_q;
  assign o_start_topMvm = start_q;
  assign o_x_vectors    = x_q;
  assign o_wts          = w_q;

endmodule

// File: tb/tb_mvm_stream_feeder.sv
// tb/tb_mvm_stream_feeder.sv - randomized self-checking bench with a frame/TOP_MVM reference model
module tb_mvm_stream_feeder;
  import mvm_pkg::*;

  localparam int NB = 8;
  localparam int D  = 4;
  localparam int NV = 3;
  localparam int FL = NV * (D + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mvm_stream_feeder_if #(.NUM_BIT(NB)) strm_if ();

  logic [NV-1:0][D-1:0][NB-1:0] x_vectors;
  logic [NV-1:0][NB-1:0]        wts;
  logic                         start;
  xvec_t                        y_vector;
  logic                         is_acc;
`ifdef MVM_TIMEOUT_EN
  logic                         error;
`endif

  mvm_stream_feeder #(
    .NUM_BIT    (NB),
    .DIM        (D),
    .NUM_VECTOR (NV)
`ifdef MVM_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (32)
`endif
  ) dut (
    .i_clk_topMvm   (clk),
    .i_rst_topMvm   (rst),
    .strm           (strm_if),
    .o_x_vectors    (x_vectors),
    .o_wts          (wts),
    .o_start_topMvm (start),
    .i_y_vector     (y_vector),
    .i_isAcc        (is_acc)
`ifdef MVM_TIMEOUT_EN
    ,
    .o_error        (error)
`endif
  );

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;

  word_t frame_w [FL];
  xvec_t mx [NV];
  word_t mw [NV];

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  function automatic logic [127:0] exp_x();
    logic [127:0] r = '0;
    for (int g = 0; g < NV; g++) r[g*D*NB +: D*NB] = mx[g];
    return r;
  endfunction

  function automatic logic [127:0] exp_w();
    logic [127:0] r = '0;
    for (int g = 0; g < NV; g++) r[g*NB +: NB] = mw[g];
    return r;
  endfunction

  // Word k of a frame belongs to group k/(D+1); position D within a group is the weight
  task automatic model_load_frame();
    for (int k = 0; k < FL; k++) begin
      if (k % (D + 1) < D) mx[k / (D + 1)][k % (D + 1)] = frame_w[k];
      else                 mw[k / (D + 1)] = frame_w[k];
    end
  endtask

  task automatic model_clear();
    for (int g = 0; g < NV; g++) begin
      mx[g] = '0;
      mw[g] = '0;
    end
  endtask

  task automatic fill_frame(input bit counting);
    for (int k = 0; k < FL; k++) frame_w[k] = counting ? word_t'(k + 1) : word_t'($urandom);
  endtask

  task automatic send_frame(input int n_words, input bit gaps);
    bit rdy;
    bit ok;
    int n;
    for (int k = 0; k < n_words; k++) begin
      if (gaps) begin
        strm_if.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      strm_if.in_valid = 1'b1;
      strm_if.in_data  = frame_w[k];
      ok = 1'b0;
      n  = 0;
      while (!ok && n < 50) begin
        rdy = strm_if.in_ready;
        @(posedge clk); #1;
        n++;
        if (rdy) ok = 1'b1;
      end
      if (!ok) check_eq("in_accept_timeout", 128'(0), 128'(1));
    end
    strm_if.in_valid = 1'b0;
    if (n_words == FL) begin
      model_load_frame();
      check_eq("start_latency", 128'(start), 128'(1));
      check_eq("start_in_ready", 128'(strm_if.in_ready), 128'(0));
      check_eq("x_vectors", 128'(x_vectors), exp_x());
      check_eq("wts", 128'(wts), exp_w());
    end
  endtask

  task automatic mvm_respond(input int delay, input xvec_t y, input bit poke_in);
    for (int c = 0; c < delay; c++) begin
      if (poke_in) begin
        strm_if.in_valid = 1'b1;
        strm_if.in_data  = word_t'($urandom);
      end
      @(posedge clk); #1;
      if (c == 0) check_eq("start_one_cycle", 128'(start), 128'(0));
      if (poke_in) check_eq("wait_in_ready", 128'(strm_if.in_ready), 128'(0));
      if (c == delay - 1) check_eq("wait_no_valid", 128'(strm_if.out_valid), 128'(0));
    end
    strm_if.in_valid = 1'b0;
    is_acc   = 1'b0;
    y_vector = y;
    @(posedge clk); #1;
    is_acc   = 1'b1;
    y_vector = xvec_t'({$urandom, $urandom});
    check_eq("capture_latency", 128'(strm_if.out_valid), 128'(1));
    check_eq("x_stable", 128'(x_vectors), exp_x());
    check_eq("w_stable", 128'(wts), exp_w());
  endtask

  // mode 0: always ready, 1: toggle 1/0, 2: random; stop_at >= 0 returns before that word's handshake
  task automatic drain(input xvec_t y, input int mode, input int stop_at);
    int  k = 0;
    int  n = 0;
    bit  rdy;
    bit  stalled = 1'b0;
    word_t held = '0;
    while (k < D && n < 200) begin
      if (k == stop_at) return;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (n % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      strm_if.out_ready = rdy;
      check_eq("out_valid", 128'(strm_if.out_valid), 128'(1));
      if (stalled) check_eq("hold_data", 128'(strm_if.out_data), 128'(held));
      check_eq("out_data", 128'(strm_if.out_data), 128'(y[k]));
      check_eq("out_last", 128'(strm_if.out_last), 128'(k == D - 1));
      held    = strm_if.out_data;
      stalled = !rdy;
      if (rdy) k++;
      @(posedge clk); #1;
      n++;
    end
    strm_if.out_ready = 1'b0;
    if (k < D) check_eq("drain_timeout", 128'(0), 128'(1));
    check_eq("drain_end_valid", 128'(strm_if.out_valid), 128'(0));
    check_eq("drain_end_in_ready", 128'(strm_if.in_ready), 128'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, 128'(strm_if.in_ready), 128'(1));
    check_eq({tag, "_start"}, 128'(start), 128'(0));
    check_eq({tag, "_out_valid"}, 128'(strm_if.out_valid), 128'(0));
    check_eq({tag, "_out_data"}, 128'(strm_if.out_data), 128'(0));
    check_eq({tag, "_out_last"}, 128'(strm_if.out_last), 128'(0));
    check_eq({tag, "_x"}, 128'(x_vectors), 128'(0));
    check_eq({tag, "_w"}, 128'(wts), 128'(0));
`ifdef MVM_TIMEOUT_EN
    check_eq({tag, "_error"}, 128'(error), 128'(0));
`endif
  endtask

  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_values(tag);
    strm_if.in_valid  = 1'b0;
    strm_if.out_ready = 1'b0;
    is_acc            = 1'b1;
    model_clear();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input bit counting, input bit gaps, input int delay,
                           input xvec_t y, input int mode);
    int s0;
    fill_frame(counting);
    s0 = start_cnt;
    send_frame(FL, gaps);
    mvm_respond(delay, y, 1'b1);
    check_eq("start_count", 128'(start_cnt - s0), 128'(1));
    drain(y, mode, -1);
  endtask

  xvec_t y_fix;
  xvec_t y_rnd;

  initial begin
    rst               = 1'b1;
    is_acc            = 1'b1;
    y_vector          = '0;
    strm_if.in_valid  = 1'b0;
    strm_if.in_data   = '0;
    strm_if.out_ready = 1'b0;
    model_clear();
    #12 check_reset_values("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // isAcc low while loading must not capture anything
    is_acc   = 1'b0;
    y_vector = xvec_t'(32'hdeadbeef);
    @(posedge clk); #1;
    is_acc   = 1'b1;
    check_eq("load_isacc_valid", 128'(strm_if.out_valid), 128'(0));
    check_eq("load_isacc_ready", 128'(strm_if.in_ready), 128'(1));

    y_fix = {8'h40, 8'h30, 8'h20, 8'h10};
    fill_frame(1'b1);
    send_frame(FL, 1'b0);
    check_eq("x0_const", 128'(x_vectors[0]), 128'({8'd4, 8'd3, 8'd2, 8'd1}));
    check_eq("w0_const", 128'(wts[0]), 128'(5));
    check_eq("x2_const", 128'(x_vectors[2]), 128'({8'd14, 8'd13, 8'd12, 8'd11}));
    check_eq("w2_const", 128'(wts[2]), 128'(15));
    mvm_respond(20, y_fix, 1'b1);
    drain(y_fix, 0, -1);

    // single-cycle isAcc low in the very first WAIT cycle, toggled backpressure
    for (int e = 0; e < D; e++) y_rnd[e] = word_t'($urandom);
    run_frame(1'b0, 1'b1, 1, y_rnd, 1);

    // abort at word 7
    fill_frame(1'b0);
    send_frame(7, 1'b0);
    apply_reset("rst_load");
    run_frame(1'b1, 1'b0, 20, y_fix, 0);

    // abort mid-drain after two handshakes
    fill_frame(1'b1);
    send_frame(FL, 1'b0);
    mvm_respond(20, y_fix, 1'b0);
    drain(y_fix, 1, 2);
    apply_reset("rst_drain");
    run_frame(1'b1, 1'b0, 20, y_fix, 1);

    for (int f = 0; f < 5; f++) begin
      for (int e = 0; e < D; e++) y_rnd[e] = word_t'($urandom);
      run_frame(1'b0, 1'b1, $urandom_range(1, 30), y_rnd, 2);
    end

`ifdef MVM_TIMEOUT_EN
    fill_frame(1'b0);
    send_frame(FL, 1'b0);
    repeat (32) begin
      @(posedge clk); #1;
    end
    check_eq("to_error_early", 128'(error), 128'(0));
    check_eq("to_ready_early", 128'(strm_if.in_ready), 128'(0));
    @(posedge clk); #1;
    check_eq("to_error", 128'(error), 128'(1));
    check_eq("to_in_ready", 128'(strm_if.in_ready), 128'(1));
    check_eq("to_no_valid", 128'(strm_if.out_valid), 128'(0));
    @(posedge clk); #1;
    check_eq("to_sticky", 128'(error), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=%0d", 1, 0);
    $fatal(1, "global timeout");
  end

endmodule
